// File: rtl/counter_ctrl.sv
// Run controller for the prototype counter: rate prescaler, IDLE/RUN/PAUSE
// sequencing and a four-digit BCD up/down count with registered outputs.
module counter_ctrl #(
  parameter int unsigned DIV = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up_dn,
  output logic        run,
  output logic        tick,
  output logic        wrap,
  output logic [15:0] bcd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [29:0] Q_LAST = 30'(DIV - 1);

  state_t      state_q, state_d;
  logic [29:0] q_q, q_d;
  logic        run_q, run_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;
  logic [15:0] bcd_q, bcd_d;

  logic [15:0] bcd_step;
  logic        carry;

  // Decimal increment/decrement; a carry/borrow out of the top digit is a wrap.
  always_comb begin
    bcd_step = bcd_q;
    carry    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (up_dn) begin
          if (bcd_q[4*i +: 4] >= 4'd9) begin
            bcd_step[4*i +: 4] = 4'd0;
          end else begin
            bcd_step[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry              = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            bcd_step[4*i +: 4] = 4'd9;
          end else begin
            bcd_step[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            carry              = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    bcd_d   = bcd_q;
    if (clear) begin
      state_d = S_IDLE;
      q_d     = '0;
      bcd_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          q_d = '0;
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          // A stop on the terminal count suppresses the step and parks Q there.
          if (q_q == Q_LAST) begin
            if (!stop) begin
              q_d    = '0;
              tick_d = 1'b1;
              wrap_d = carry;
              bcd_d  = bcd_step;
            end
          end else begin
            q_d = q_q + 30'd1;
          end
          if (stop) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (start && !stop) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
    run_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      bcd_q   <= bcd_d;
    end
  end

  assign run  = run_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign bcd  = bcd_q;

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run controller for the prototype counter. Holds its own rate prescaler and sequences a 4‑digit BCD count through IDLE/RUN/PAUSE from single‑cycle start/stop/clear commands. Emits one advance pulse per rate period, so the display and LED logic downstream need no divider of their own. Sits between the debounced button pulses and the seven‑segment display driver.

## Interface

- DIV, 10000000: prescaler period in clk cycles; range 2..2^30; one count step per DIV cycles while running.
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  reset, asynchronous, active‑high.
- start  in  1  single‑cycle command pulse, synchronous to clk.
- stop  in  1  single‑cycle command pulse, synchronous to clk.
- clear  in  1  single‑cycle command pulse, synchronous to clk.
- up_dn  in  1  count direction: 1 = up, 0 = down; sampled only on step edges.
- run  out  1  high while state is RUN.
- tick  out  1  one‑cycle pulse in the cycle after each count step; aligned with the updated bcd value.
- wrap  out  1  one‑cycle pulse coincident with tick when the step wrapped (9999→0000 or 0000→9999).
- bcd  out  16  count value as four BCD digits; [15:12] is thousands, [3:0] is units.

## Operation

- Prescaler: 30‑bit counter Q.
  - IDLE: Q is held at 0.
  - RUN: Q increments every cycle. When Q == DIV‑1, the next edge sets Q to 0 and performs a step.
  - PAUSE: Q holds its value. Resuming continues the partial period; it does not restart it.
- State machine: IDLE, RUN, PAUSE. Reset state is IDLE.
  - IDLE + start → RUN.
  - RUN + stop → PAUSE.
  - PAUSE + start → RUN.
  - clear in any state → IDLE, with bcd = 0 and Q = 0.
  - All other commands are ignored, e.g. stop in IDLE or start in RUN.
- Priority: clear > stop > start.
  - start and stop in the same cycle in PAUSE: stay in PAUSE.
  - start and stop in the same cycle in RUN: go to PAUSE.
- Step, up (up_dn = 1):
  - Units digit increments, with a decimal carry ripple through all four digits.
  - 9999 → 0000 and asserts wrap.
- Step, down (up_dn = 0):
  - Units digit decrements, with a decimal borrow ripple.
  - 0000 → 9999 and asserts wrap.
- Each digit is always in the range 0..9. Non‑BCD digit values are never produced.
- Command that coincides with a step edge (Q == DIV‑1 while in RUN):
  - stop or clear takes effect and the step is suppressed: no tick, no bcd change.
  - After stop, Q stays at DIV‑1, so a later start produces a step on the first RUN edge.
- run is registered from the state: it equals 1 exactly in the cycles where the state is RUN.

## Timing

- Reset values: run = 0, tick = 0, wrap = 0, bcd = 0x0000, Q = 0, state IDLE.
  - Reset takes effect immediately on assertion, including in the middle of a RUN.
  - The first edge after rst deasserts is a normal operating edge.
- start sampled at edge E from IDLE:
  - run is high from E.
  - First step at edge E+DIV; tick and the new bcd are visible in the cycle after E+DIV.
- Steps continue every DIV cycles while in RUN.
- tick and wrap are high for exactly one cycle and are low in all other cycles.
- Pause/resume: if stop is sampled with Q = k and start is sampled later at edge S, the next step occurs at edge S + (DIV‑1‑k).
  - Total RUN time between steps is exactly DIV edges.
- clear sampled at edge C:
  - bcd = 0 and run = 0 from C.
  - No tick or wrap is generated by the clear.
- Latency from a command to run or bcd: one edge. No combinational path exists from inputs to outputs.

## Test plan

- Reset: assert rst mid‑cycle while in RUN with bcd = 0x0042 → bcd = 0, run = 0, tick = 0 immediately, without waiting for a clk edge.
- DIV = 5, up_dn = 1, start pulse → run = 1 next cycle; tick every 5 cycles; bcd goes 0001, 0002, 0003; no wrap.
- DIV = 5, stop 2 edges into a period, wait 20 cycles, start → no tick during PAUSE; next tick 3 edges after start; bcd increments by exactly 1.
- Preload by stepping, up, from 9998 → two ticks give bcd 9999 then 0000, with wrap high together with the second tick only.
- Down from 0000 (clear, start, up_dn = 0) → first step gives bcd 9999 and wrap = 1; next step gives 9998 and wrap = 0. A digit borrow case 1000 → 0999 is checked.
- Collisions at Q == DIV‑1:
  - stop at that cycle → no step.
  - clear at that cycle → bcd = 0 and no tick.
  - start + stop together in PAUSE → remains in PAUSE.
  - stop in IDLE → ignored.
